// File: rtl/udp_axil_regbank.sv
// udp_axil_regbank: AXI4-Lite register bank with byte strobes, SLVERR and per-register write pulses.
// Define UDP_REGBANK_STATUS_EN to turn the top NUM_STATUS registers into read-only status words.
module udp_axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_STATUS = 2
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                  wr_pulse,
  input  logic [NUM_STATUS*C_S_AXI_DATA_WIDTH-1:0] status_in
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int NB = DW / 8;
  localparam int ADDR_LSB = (DW == 64) ? 3 : 2;
  localparam int IDX_W = AW - ADDR_LSB;
`ifdef UDP_REGBANK_STATUS_EN
  localparam int WR_LIMIT = NUM_REGS - NUM_STATUS;
`else
  localparam int WR_LIMIT = NUM_REGS;
`endif

  typedef enum logic [2:0] {
    IDLE, AW_HELD, W_HELD, COMMIT, RESP
  } wstate_t;

  wstate_t state, state_nx;

  logic [DW-1:0]    regs [NUM_REGS];
  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] ar_idx;
  logic [DW-1:0]    w_data;
  logic [NB-1:0]    w_strb;
  logic             aw_hs, w_hs, ar_hs;
  logic             wr_ok, rd_ok;
  logic [DW-1:0]    rd_word;
  logic             unused_ok;

  assign S_AXI_AWREADY = !S_AXI_ARESET &&
                         (state == IDLE || state == W_HELD);
  assign S_AXI_WREADY  = !S_AXI_ARESET &&
                         (state == IDLE || state == AW_HELD);
  assign S_AXI_ARREADY = !S_AXI_ARESET && !S_AXI_RVALID;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign ar_idx = S_AXI_ARADDR[AW-1:ADDR_LSB];
  assign wr_ok  = 32'(aw_idx) < 32'(WR_LIMIT);
  assign rd_ok  = 32'(ar_idx) < 32'(NUM_REGS);

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0],
                       S_AXI_ARADDR[ADDR_LSB-1:0], status_in};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (aw_hs && w_hs) state_nx = COMMIT;
        else if (aw_hs)    state_nx = AW_HELD;
        else if (w_hs)     state_nx = W_HELD;
      end
      AW_HELD: if (w_hs)  state_nx = COMMIT;
      W_HELD:  if (aw_hs) state_nx = COMMIT;
      COMMIT:  state_nx = RESP;
      RESP:    if (S_AXI_BVALID && S_AXI_BREADY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state        <= IDLE;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= 2'b00;
      wr_pulse     <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      state    <= state_nx;
      wr_pulse <= '0;
      if (aw_hs) aw_idx <= S_AXI_AWADDR[AW-1:ADDR_LSB];
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (state == COMMIT && wr_ok) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (32'(aw_idx) == 32'(k)) begin
            wr_pulse[k] <= 1'b1;
            for (int b = 0; b < NB; b++)
              if (w_strb[b]) regs[k][b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
      end
      // Response is raised one cycle after entering RESP.
      if (state == RESP && !S_AXI_BVALID) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_ok ? 2'b00 : 2'b10;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (32'(ar_idx) == 32'(k)) rd_word = regs[k];
`ifdef UDP_REGBANK_STATUS_EN
    for (int j = 0; j < NUM_STATUS; j++)
      if (32'(ar_idx) == 32'(NUM_REGS - NUM_STATUS + j))
        rd_word = status_in[j*DW +: DW];
`endif
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= 2'b00;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_word;
      S_AXI_RRESP  <= rd_ok ? 2'b00 : 2'b10;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DW +: DW] = regs[g];
  end

endmodule

// File: tb/tb_udp_axil_regbank.sv
// tb_udp_axil_regbank: directed scoreboard bench for udp_axil_regbank.
// Runs with or without UDP_REGBANK_STATUS_EN.
module tb_udp_axil_regbank;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 8;
  localparam int NS = 2;
`ifdef UDP_REGBANK_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic bvalid, bready, arvalid, arready, rvalid, rready;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0] wr_pulse;
  logic [NS*DW-1:0] status_in;

  always #5 clk = ~clk;

  udp_axil_regbank dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse),
    .status_in(status_in)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl [NR];
  int exp_pulse [NR];
  int got_pulse [NR];
  logic [1:0] bq [$];
  logic [33:0] rq [$];

  always @(negedge clk)
    if (!rst)
      for (int k = 0; k < NR; k++)
        if (wr_pulse[k]) got_pulse[k]++;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] wresp_of(input logic [7:0] a);
    int i;
    i = int'(a[7:2]);
    if (i >= NR || (STAT && i >= NR - NS)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [33:0] rexp(input logic [7:0] a);
    int i;
    i = int'(a[7:2]);
    if (i >= NR) return {2'b10, 32'h0};
    if (STAT && i >= NR - NS)
      return {2'b00, status_in[(i-(NR-NS))*32 +: 32]};
    return {2'b00, mdl[i]};
  endfunction

  function automatic void mdl_wr(input logic [7:0] a,
                                 input logic [31:0] d,
                                 input logic [3:0] s);
    int i;
    i = int'(a[7:2]);
    if (wresp_of(a) != 2'b00) return;
    exp_pulse[i]++;
    for (int b = 0; b < 4; b++)
      if (s[b]) mdl[i][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic logic [255:0] mdl_flat();
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < NR; k++) f[k*32 +: 32] = mdl[k];
    return f;
  endfunction

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    int c;
    logic ah, wh;
    logic [1:0] e;
    bq.push_back(wresp_of(a));
    mdl_wr(a, d, s);
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    c = 0;
    while ((awvalid || wvalid) && c < 50) begin
      ah = awvalid && awready;
      wh = wvalid && wready;
      @(negedge clk);
      c++;
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
    end
    chk("wr_accept", {awvalid, wvalid}, 2'b00);
    c = 1;
    while (!bvalid && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("b_latency", c, 3);
    e = bq.pop_front();
    chk("bresp", bresp, e);
    @(negedge clk);
    chk("b_done", bvalid, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a);
    int c;
    logic h;
    logic [33:0] e;
    rq.push_back(rexp(a));
    araddr = a; arvalid = 1'b1;
    c = 0;
    while (arvalid && c < 50) begin
      h = arready;
      @(negedge clk);
      c++;
      if (h) arvalid = 1'b0;
    end
    chk("r_latency", {arvalid, rvalid}, 2'b01);
    e = rq.pop_front();
    chk($sformatf("rd_%0h", a), {rresp, rdata}, e);
    @(negedge clk);
  endtask

  task automatic ord(input bit w_first);
    logic [1:0] e;
    bq.push_back(wresp_of(8'h04));
    mdl_wr(8'h04, 32'hA5A5A5A5, 4'hF);
    awaddr = 8'h04; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    if (w_first) wvalid = 1'b1; else awvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; awvalid = 1'b0;
    if (w_first)
      chk("w_held_ready", {awready, wready}, 2'b10);
    else
      chk("aw_held_ready", {awready, wready}, 2'b01);
    repeat (2) @(negedge clk);
    if (w_first) awvalid = 1'b1; else wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; awvalid = 1'b0;
    chk("ord_n1_bvalid", bvalid, 1'b0);
    @(negedge clk);
    chk("ord_n2_bvalid", bvalid, 1'b0);
    chk("ord_pulse", wr_pulse, 8'h02);
    chk("ord_reg1", reg_out[63:32], 32'hA5A5A5A5);
    @(negedge clk);
    chk("ord_n3_bvalid", bvalid, 1'b1);
    e = bq.pop_front();
    chk("ord_bresp", bresp, e);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] e;
    logic [33:0] re;
    int c;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b1; araddr = '0;
    arvalid = 1'b0; rready = 1'b1;
    status_in = {32'hDEADBEEF, 32'hCAFEF00D};
    foreach (mdl[k]) mdl[k] = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_regout", reg_out, '0);
    chk("rst_pulse", wr_pulse, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < NR; i++) wr(8'(i*4), 32'(i+1), 4'hF);
    for (int i = 0; i < NR; i++) rd(8'(i*4));
    for (int k = 0; k < NR; k++)
      chk($sformatf("pulses_%0d", k), got_pulse[k], exp_pulse[k]);

    ord(1'b1);
    wr(8'h04, 32'h0, 4'hF);
    ord(1'b0);
    rd(8'h04);

    wr(8'h08, 32'h11223344, 4'hF);
    wr(8'h08, 32'hFFFFFFFF, 4'b0101);
    chk("strobe_reg2", reg_out[95:64], 32'h11FF33FF);
    wr(8'h08, 32'h0, 4'h0);
    rd(8'h08);

    wr(8'h20, 32'h12345678, 4'hF);
    chk("oor_regout", reg_out, mdl_flat());
    rd(8'h20);

    rd(8'h1C);
    wr(8'h1C, 32'h87654321, 4'hF);
    rd(8'h1C);
    chk("regout_model", reg_out, mdl_flat());
    for (int k = 0; k < NR; k++)
      chk($sformatf("pulses2_%0d", k), got_pulse[k], exp_pulse[k]);

    bready = 1'b0; rready = 1'b0;
    bq.push_back(wresp_of(8'h0C));
    mdl_wr(8'h0C, 32'h0BADF00D, 4'hF);
    rq.push_back(rexp(8'h00));
    awaddr = 8'h0C; wdata = 32'h0BADF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; araddr = 8'h00; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    c = 0;
    while (!bvalid && c < 50) begin
      @(negedge clk);
      c++;
    end
    e = bq.pop_front();
    for (int i = 0; i < 10; i++) begin
      chk("hold_b", {bvalid, bresp}, {1'b1, e});
      chk("hold_ready", {awready, wready}, 2'b00);
      @(negedge clk);
    end
    re = rq.pop_front();
    chk("hold_r", {rvalid, rresp, rdata}, {1'b1, re});
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {bvalid, rvalid}, 2'b00);
    chk("mid_rst_resp", {bresp, rresp, rdata}, '0);
    chk("mid_rst_ready", {awready, wready, arready}, 3'b000);
    chk("mid_rst_regout", reg_out, '0);
    chk("mid_rst_pulse", wr_pulse, '0);
    foreach (mdl[k]) mdl[k] = '0;
    bready = 1'b1; rready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", {awready, wready, arready}, 3'b111);
    repeat (2) begin
      @(negedge clk);
      chk("rel_no_b", {bvalid, rvalid}, 2'b00);
    end
    rd(8'h0C);
    wr(8'h10, 32'h5555AAAA, 4'hF);
    rd(8'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
